// File: rtl/dm_port_arbiter_pkg.sv
// Shared constants and types for the data-memory port arbiter.
package dm_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int RD_LAT_DEF = 1;
   localparam int LAT_W      = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wea;
   } dm_req_t;

   // Byte enables only reach the BRAM on writes.
   function automatic logic [3:0] eff_wea(input logic we, input logic [3:0] wea);
      return we ? wea : 4'b0000;
   endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Requester-side handshake bundle: one instance per requester (cpu, dbg).
interface dm_port_arbiter_if;

   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wea;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, wea, input ack, rdata);
   modport slave  (input req, we, addr, wdata, wea, output ack, rdata);

endinterface

// File: rtl/dm_port_arbiter_rr_arb2.sv
// Two-input round-robin grant; rr_last only moves when both requesters collide.
module dm_port_arbiter_rr_arb2
   import dm_port_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_cpu_i,
   input  logic req_dbg_i,
   input  logic upd_en_i,
   output logic gnt_valid_o,
   output logic gnt_id_o
);

   logic rr_last_q;
   logic rr_last_d;
   logic both;

   assign both        = req_cpu_i & req_dbg_i;
   assign gnt_valid_o = req_cpu_i | req_dbg_i;

   always_comb begin
      gnt_id_o = REQ_CPU;
      if (both) begin
         gnt_id_o = ~rr_last_q;
      end else if (req_dbg_i) begin
         gnt_id_o = REQ_DBG;
      end
      rr_last_d = (upd_en_i && both) ? gnt_id_o : rr_last_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_last_q <= REQ_DBG;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares one data-memory BRAM port between the CPU MEM stage and a debug port,
// one transaction at a time, tracking the BRAM read latency.
module dm_port_arbiter
   import dm_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   dm_port_arbiter_if.slave  cpu_if,
   dm_port_arbiter_if.slave  dbg_if,
   output logic              cpu_stall_o,
   output logic              dm_en_o,
   output logic [ADDR_W-1:0] dm_addr_o,
   output logic [31:0]       dm_wdata_o,
   output logic [3:0]        dm_wea_o,
   input  logic [31:0]       dm_rdata_i
);

   logic [1:0]       state_q, state_d;
   logic             owner_q, owner_d;
   logic             we_q, we_d;
   logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic [31:0]      cpu_hold_q, cpu_hold_d;
   logic [31:0]      dbg_hold_q, dbg_hold_d;

   logic    gnt_valid, gnt_id;
   logic    idle, issue, resp, rd_resp;
   dm_req_t cpu_req, dbg_req, sel_req;
   logic    unused_sel_bits;

   assign idle  = (state_q == ST_IDLE);
   assign issue = idle & gnt_valid;
   assign resp  = (state_q == ST_RESP);
   assign rd_resp = resp & ~we_q;

   assign cpu_req = {cpu_if.we, cpu_if.addr, cpu_if.wdata, cpu_if.wea};
   assign dbg_req = {dbg_if.we, dbg_if.addr, dbg_if.wdata, dbg_if.wea};
   assign sel_req = (gnt_id == REQ_DBG) ? dbg_req : cpu_req;
   assign unused_sel_bits = ^{sel_req.addr[1:0], sel_req.addr[31:ADDR_W+2]};

   dm_port_arbiter_rr_arb2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_cpu_i   (cpu_if.req),
      .req_dbg_i   (dbg_if.req),
      .upd_en_i    (idle),
      .gnt_valid_o (gnt_valid),
      .gnt_id_o    (gnt_id)
   );

   always_comb begin
      dm_en_o    = 1'b0;
      dm_addr_o  = '0;
      dm_wdata_o = '0;
      dm_wea_o   = 4'b0000;
      if (issue) begin
         dm_en_o    = 1'b1;
         dm_addr_o  = sel_req.addr[ADDR_W+1:2];
         dm_wdata_o = sel_req.wdata;
         dm_wea_o   = eff_wea(sel_req.we, sel_req.wea);
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      lat_cnt_d = lat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               owner_d = gnt_id;
               we_d    = sel_req.we;
               if (sel_req.we || RD_LAT == 1) begin
                  state_d = ST_RESP;
               end else begin
                  state_d   = ST_WAIT;
                  lat_cnt_d = LAT_W'(RD_LAT - 1);
               end
            end
         end
         ST_WAIT: begin
            lat_cnt_d = lat_cnt_q - 1'b1;
            if (lat_cnt_q <= LAT_W'(1)) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Read data is forwarded in the ack cycle and also captured for later use.
   assign cpu_if.ack   = resp & (owner_q == REQ_CPU);
   assign dbg_if.ack   = resp & (owner_q == REQ_DBG);
   assign cpu_if.rdata = (rd_resp && owner_q == REQ_CPU) ? dm_rdata_i : cpu_hold_q;
   assign dbg_if.rdata = (rd_resp && owner_q == REQ_DBG) ? dm_rdata_i : dbg_hold_q;
   assign cpu_hold_d   = (rd_resp && owner_q == REQ_CPU) ? dm_rdata_i : cpu_hold_q;
   assign dbg_hold_d   = (rd_resp && owner_q == REQ_DBG) ? dm_rdata_i : dbg_hold_q;
   assign cpu_stall_o  = cpu_if.req & ~cpu_if.ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= REQ_CPU;
         we_q       <= 1'b0;
         lat_cnt_q  <= '0;
         cpu_hold_q <= '0;
         dbg_hold_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         lat_cnt_q  <= lat_cnt_d;
         cpu_hold_q <= cpu_hold_d;
         dbg_hold_q <= dbg_hold_d;
      end
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized bench for dm_port_arbiter against a transaction-level model.
module tb_dm_port_arbiter;
   import dm_port_arbiter_pkg::*;

   localparam int ADDR_W = 12;
   localparam int RD_LAT = 3;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tb_fill = 1'b1;

   dm_port_arbiter_if cpu_if ();
   dm_port_arbiter_if dbg_if ();

   logic              cpu_stall, dm_en;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_wdata, dm_rdata;
   logic [3:0]        dm_wea;

   dm_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_if      (cpu_if),
      .dbg_if      (dbg_if),
      .cpu_stall_o (cpu_stall),
      .dm_en_o     (dm_en),
      .dm_addr_o   (dm_addr),
      .dm_wdata_o  (dm_wdata),
      .dm_wea_o    (dm_wea),
      .dm_rdata_i  (dm_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
   endfunction

   // BRAM model: read-first, data appears RD_LAT cycles after the enable cycle.
   logic [31:0] bram [DEPTH];
   logic [31:0] pipe [RD_LAT];
   always @(posedge clk) begin
      if (tb_fill) begin
         for (int i = 0; i < DEPTH; i++) bram[i] <= init_word(i);
      end else if (dm_en) begin
         pipe[0] <= bram[dm_addr];
         for (int b = 0; b < 4; b++)
            if (dm_wea[b]) bram[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign dm_rdata = pipe[RD_LAT-1];

   // Reference model state
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   bit          busy;
   int          ack_cyc;
   logic        own, own_we, rr_last;
   logic [31:0] own_rd, own_addr;
   logic [31:0] hold_cpu, hold_dbg;
   logic [31:0] shadow [DEPTH];
   bit          lack_cpu, lack_dbg;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      busy = 0; rr_last = REQ_DBG; hold_cpu = '0; hold_dbg = '0;
      lack_cpu = 0; lack_dbg = 0;
   endtask

   task automatic model_cycle();
      logic              e_en, e_cack, e_dack, g, r_we;
      logic [3:0]        e_wea, r_wea;
      logic [31:0]       r_addr, r_wd, rd_exp;
      logic [ADDR_W-1:0] widx;
      e_en = 0; e_cack = 0; e_dack = 0; e_wea = '0; rd_exp = '0;
      r_addr = '0; r_wd = '0; widx = '0; g = REQ_CPU;
      cyc++;
      if (busy && cyc == ack_cyc) begin
         if (own == REQ_CPU) e_cack = 1; else e_dack = 1;
         rd_exp = own_we ? (own == REQ_CPU ? hold_cpu : hold_dbg) : own_rd;
      end else if (!busy && (cpu_if.req || dbg_if.req)) begin
         if (cpu_if.req && dbg_if.req) begin
            g = ~rr_last; rr_last = g;
         end else begin
            g = dbg_if.req ? REQ_DBG : REQ_CPU;
         end
         r_we   = (g == REQ_DBG) ? dbg_if.we    : cpu_if.we;
         r_addr = (g == REQ_DBG) ? dbg_if.addr  : cpu_if.addr;
         r_wd   = (g == REQ_DBG) ? dbg_if.wdata : cpu_if.wdata;
         r_wea  = (g == REQ_DBG) ? dbg_if.wea   : cpu_if.wea;
         widx   = r_addr[ADDR_W+1:2];
         e_en   = 1;
         e_wea  = r_we ? r_wea : 4'b0000;
         own_rd = shadow[widx];
         for (int b = 0; b < 4; b++)
            if (e_wea[b]) shadow[widx][8*b +: 8] = r_wd[8*b +: 8];
         busy = 1; own = g; own_we = r_we; own_addr = r_addr;
         ack_cyc = cyc + (r_we ? 1 : RD_LAT);
      end
      check_eq("dm_en", 32'(dm_en), 32'(e_en));
      check_eq("dm_wea", 32'(dm_wea), 32'(e_wea));
      if (e_en) begin
         check_eq("dm_addr", 32'(dm_addr), 32'(widx));
         check_eq("dm_wdata", dm_wdata, r_wd);
      end
      check_eq("cpu_ack", 32'(cpu_if.ack), 32'(e_cack));
      check_eq("dbg_ack", 32'(dbg_if.ack), 32'(e_dack));
      check_eq("cpu_stall", 32'(cpu_stall), 32'(cpu_if.req & ~e_cack));
      check_eq("cpu_rdata", cpu_if.rdata, e_cack ? rd_exp : hold_cpu);
      check_eq("dbg_rdata", dbg_if.rdata, e_dack ? rd_exp : hold_dbg);
      lack_cpu = e_cack; lack_dbg = e_dack;
      if (e_cack || e_dack) begin
         if (!own_we) begin
            if (own == REQ_CPU) hold_cpu = rd_exp; else hold_dbg = rd_exp;
         end
         busy = 0;
         $display("[TB] cyc %0d ack %s %s addr %h data %h", cyc,
                  own == REQ_CPU ? "cpu" : "dbg", own_we ? "wr" : "rd", own_addr,
                  own_we ? 32'h0 : rd_exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit k, input bit v);
      if (k) dbg_if.req = v; else cpu_if.req = v;
   endtask

   task automatic set_fields(input bit k, input bit we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] wea);
      if (k) begin
         dbg_if.we = we; dbg_if.addr = a; dbg_if.wdata = wd; dbg_if.wea = wea;
      end else begin
         cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = wd; cpu_if.wea = wea;
      end
   endtask

   task automatic rand_fields(input bit k);
      logic [31:0] a;
      a = $urandom;
      a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 31));
      set_fields(k, 1'($urandom), a, $urandom, 4'($urandom));
   endtask

   task automatic run_txn(input bit k, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wea);
      bit done;
      done = 0;
      set_fields(k, we, a, wd, wea);
      set_req(k, 1);
      for (int i = 0; i < 12 && !done; i++) begin
         step();
         done = k ? lack_dbg : lack_cpu;
      end
      check_eq("txn_done", 32'(done), 32'd1);
      set_req(k, 0);
   endtask

   initial begin
      bit done;
      set_fields(0, 0, '0, '0, '0);
      set_fields(1, 0, '0, '0, '0);
      cpu_if.req = 0; dbg_if.req = 0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_dm_en", 32'(dm_en), 32'd0);
      check_eq("rst_dm_addr", 32'(dm_addr), 32'd0);
      check_eq("rst_dm_wdata", dm_wdata, 32'd0);
      check_eq("rst_cpu_ack", 32'(cpu_if.ack), 32'd0);
      check_eq("rst_dbg_rdata", dbg_if.rdata, 32'd0);
      tb_fill = 0;
      @(negedge clk); rst = 0;
      @(posedge clk); #1;

      // Directed: plan writes and reads
      run_txn(0, 1, 32'h0000_0104, 32'hA5A5_A5A5, 4'b0011);
      run_txn(1, 1, 32'hF000_0202, 32'hDEAD_BEEF, 4'b1111);
      run_txn(0, 0, 32'h0000_0200, 32'h1111_1111, 4'b1111);
      repeat (2) step();

      // Both held on writes: grants must alternate
      set_fields(0, 1, 32'h0000_0010, 32'h0102_0304, 4'b1111);
      set_fields(1, 1, 32'h0000_0020, 32'h0A0B_0C0D, 4'b1111);
      cpu_if.req = 1; dbg_if.req = 1;
      repeat (8) step();
      cpu_if.req = 0; dbg_if.req = 0;
      repeat (3) step();

      // dbg read in flight, cpu arrives during WAIT
      set_fields(1, 0, 32'h0000_0200, '0, 4'b0000);
      dbg_if.req = 1;
      repeat (2) step();
      set_fields(0, 0, 32'h0000_0104, '0, 4'b1111);
      cpu_if.req = 1;
      done = 0;
      for (int i = 0; i < 16 && !done; i++) begin
         step();
         if (lack_dbg) dbg_if.req = 0;
         done = lack_cpu;
      end
      check_eq("cpu_after_dbg", 32'(done), 32'd1);
      cpu_if.req = 0;
      step();

      // Reset during WAIT aborts the read
      set_fields(0, 0, 32'h0000_0040, '0, 4'b0000);
      cpu_if.req = 1;
      repeat (2) step();
      cpu_if.req = 0;
      rst = 1;
      #1;
      check_eq("arst_dm_en", 32'(dm_en), 32'd0);
      check_eq("arst_cpu_ack", 32'(cpu_if.ack), 32'd0);
      check_eq("arst_cpu_rdata", cpu_if.rdata, 32'd0);
      check_eq("arst_dbg_rdata", dbg_if.rdata, 32'd0);
      check_eq("arst_stall", 32'(cpu_stall), 32'd0);
      @(negedge clk); rst = 0;
      model_reset();
      @(posedge clk); #1;
      repeat (4) step();
      run_txn(0, 0, 32'h0000_0104, '0, 4'b0000);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            bit acked, rq, issued;
            acked  = (k == 1) ? lack_dbg : lack_cpu;
            rq     = (k == 1) ? dbg_if.req : cpu_if.req;
            issued = busy && (own == 1'(k));
            if (acked) begin
               rand_fields(1'(k));
               set_req(1'(k), $urandom_range(0, 2) != 0);
            end else if (issued) begin
               if ($urandom_range(0, 7) == 0) set_req(1'(k), 0);
            end else if (!rq && $urandom_range(0, 1) == 1) begin
               rand_fields(1'(k));
               set_req(1'(k), 1);
            end
         end
      end
      cpu_if.req = 0; dbg_if.req = 0;
      repeat (RD_LAT + 2) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
